sync_fifo_fwft: RTL
===================

# sync_fifo_fwft

Single-clock, parametrised FIFO with first-word-fall-through read, occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags. It is the next-generation buffer for the same-clock data paths in the design, for example between the byte source and downstream consumers, where the dual-clock FIFO's synchronisers are not needed. It generalises the existing FIFO in width, depth and status reporting, and adds defined behaviour for illegal accesses.

## Interface
Parameters:
- WIDTH, 8, data word width in bits.
- POINTER, 4, address bits; DEPTH = 2**POINTER entries (16 by default).
- AFULL_THRESH, 14, almost_full asserted when count >= AFULL_THRESH; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  pop request for the head word.
- rd_data  output  WIDTH  head word (FWFT); 0 when empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  POINTER+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set by a rejected write.
- underflow  output  1  sticky; set by a rejected read.

## Operation
- State: wr_ptr and rd_ptr, each POINTER bits and wrapping modulo DEPTH; count register, POINTER+1 bits; overflow and underflow registers; storage array.
- Reset (reset_n low, asynchronous): pointers = 0, count = 0, overflow = 0, underflow = 0.
  - Output values during reset: empty = 1, full = 0, almost_empty = 1, almost_full = 0, rd_data = 0.
  - The storage array is not reset.
- Write accept condition: wr_en && (!full || rd_en).
  - On accept, the storage array at wr_ptr is written and wr_ptr increments.
  - wr_en while full without rd_en: the write is dropped, overflow is set, and no state changes.
- Read accept condition: rd_en && !empty.
  - On accept, rd_ptr increments.
  - rd_en while empty: underflow is set and no state changes, even if wr_en is high in the same cycle (no bypass).
- count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Full with wr_en and rd_en together: both are accepted; count stays at DEPTH.
- Empty with wr_en and rd_en together: write accepted, read rejected; count becomes 1 and underflow is set.
- clear: highest priority below reset.
  - Pointers, count, overflow and underflow are set to 0.
  - wr_en and rd_en are ignored in that cycle and do not set the sticky flags.
- Flag derivation: all flags decode combinationally from the registered count only. There is no combinational path from wr_en, rd_en or wr_data to any status output.
- rd_data = storage array[rd_ptr] when !empty, otherwise 0. It is an asynchronous read of the array.
- Pointer wrap: DEPTH-1 -> 0 is seamless; data order is preserved across the wrap.

## Timing
- Write to read latency: a word written at edge k is visible on rd_data, with empty = 0, in the cycle after edge k. One cycle.
- Pop: after an accepted read at edge k, the next word (or 0 if now empty) is on rd_data after edge k.
- All status outputs change only at clk edges or on asynchronous reset assertion.
- Reset released mid-operation: the FIFO restarts empty. Data in the array is considered lost.
- Throughput: one write and one read per cycle, sustained.

## Structure
- Shared package fifo_pkg holds:
  - the DEPTH derivation (1 << POINTER);
  - the count width (POINTER+1);
  - threshold range-check constants, used by elaboration-time assertions on AFULL_THRESH and AEMPTY_THRESH.
- Sub-module sync_fifo_ram: a WIDTH x DEPTH array with one synchronous write port and one asynchronous read port. No reset.
- Top level holds the pointers, count, flags, accept logic and the rd_data zero-gating.

## Test plan
- Reset then idle: reset_n low mid-run with count = 5 -> count = 0, empty = 1, almost_empty = 1, rd_data = 0, sticky flags 0. After release, the first write of 0x0A gives rd_data = 0x0A one cycle later.
- Fill and drain with defaults: write 0x0A..0x19 (16 words) -> almost_full rises at count = 14 and full at count 16. Then 16 pops return 0x0A..0x19 in order; almost_empty rises at count = 2 and empty at count 0.
- Overflow and underflow: wr_en while full -> overflow = 1 and count stays 16. rd_en while empty -> underflow = 1. Both stay set until clear is pulsed, then both are 0 and count = 0.
- Simultaneous access:
  - full plus wr_en plus rd_en -> count stays 16, oldest word popped, new word enqueued;
  - empty plus both -> count = 1, underflow = 1, rd_data = written word next cycle.
- Wrap-around: 40 cycles of a streaming write/read pattern at count = 3 -> pointers wrap at least twice, data is bit-exact in order, and no flag ever asserts.
- Parameter sweep WIDTH = 32, POINTER = 2, AFULL_THRESH = 3, AEMPTY_THRESH = 0 -> full at 4 entries, almost_full at 3, almost_empty only at 0, and all of the above scenarios pass.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the same-clock FIFO family.
//   fifo_depth()      - number of entries for a given pointer width
//   count_width()     - width of an occupancy counter able to hold 0..DEPTH
//   *_thresh_ok()     - legal-range checks for the almost-full/almost-empty
//                       thresholds, evaluated at elaboration time
package fifo_pkg;

    localparam int AFULL_THRESH_MIN  = 1;
    localparam int AEMPTY_THRESH_MIN = 0;

    function automatic int fifo_depth(input int pointer);
        return 1 << pointer;
    endfunction

    // One extra bit so that a completely full FIFO (count == DEPTH) is
    // distinguishable from an empty one.
    function automatic int count_width(input int pointer);
        return pointer + 1;
    endfunction

    function automatic bit afull_thresh_ok(input int thresh, input int pointer);
        return (thresh >= AFULL_THRESH_MIN) && (thresh <= fifo_depth(pointer));
    endfunction

    function automatic bit aempty_thresh_ok(input int thresh, input int pointer);
        return (thresh >= AEMPTY_THRESH_MIN) && (thresh <= fifo_depth(pointer) - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: WIDTH x DEPTH storage for sync_fifo_fwft.
//   clk      - write clock
//   wr_en    - write strobe, captured on the rising edge of clk
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - asynchronous read data (needed for first-word-fall-through)
// The array is deliberately not reset; the FIFO tracks validity itself.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int POINTER = 4
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [POINTER-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [POINTER-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);

    localparam int DEPTH = fifo_depth(POINTER);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO.
//   clk          - clock, all state updates on its rising edge
//   reset_n      - asynchronous active-low reset
//   clear        - synchronous flush (pointers, count, sticky flags)
//   wr_en/wr_data- write request and data
//   rd_en        - pop the head word
//   rd_data      - head word, 0 when empty
//   full/empty/almost_full/almost_empty - decoded from the registered count
//   count        - occupancy 0..DEPTH
//   overflow     - sticky, set by a write rejected because the FIFO was full
//   underflow    - sticky, set by a read rejected because the FIFO was empty
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int POINTER       = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   rd_data,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [POINTER:0]   count,
    output logic               overflow,
    output logic               underflow
);

    localparam int DEPTH = fifo_depth(POINTER);
    localparam int CW    = count_width(POINTER);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    generate
        if (!afull_thresh_ok(AFULL_THRESH, POINTER)) begin : g_afull_bad
            $error("sync_fifo_fwft: AFULL_THRESH out of range 1..DEPTH");
        end
        if (!aempty_thresh_ok(AEMPTY_THRESH, POINTER)) begin : g_aempty_bad
            $error("sync_fifo_fwft: AEMPTY_THRESH out of range 0..DEPTH-1");
        end
    endgenerate

    logic [POINTER-1:0] wr_ptr_reg, wr_ptr_next;
    logic [POINTER-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]      count_reg, count_next;
    logic               overflow_reg, overflow_next;
    logic               underflow_reg, underflow_next;
    logic               wr_accept, rd_accept, ram_we;
    logic [WIDTH-1:0]   ram_rd_data;

    // Flags come from the registered count only, so no input reaches them
    // combinationally.
    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AFULL_C);
    assign almost_empty = (count_reg <= AEMPTY_C);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A full FIFO still accepts a write when the head is popped in the same
    // cycle; the array write lands on the slot being vacated, and the async
    // read still returns the old head before the edge. There is no bypass
    // for the empty case: the read is rejected.
    assign wr_accept = wr_en && (!full || rd_en);
    assign rd_accept = rd_en && !empty;
    assign ram_we    = wr_accept && !clear;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (clear) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_next = wr_ptr_reg + POINTER'(1);
            end
            if (rd_accept) begin
                rd_ptr_next = rd_ptr_reg + POINTER'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
            if (wr_en && !wr_accept) begin
                overflow_next = 1'b1;
            end
            if (rd_en && !rd_accept) begin
                underflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    sync_fifo_ram #(
        .WIDTH   (WIDTH),
        .POINTER (POINTER)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (ram_rd_data)
    );

    // Stale array contents must never leak out while the FIFO is empty.
    assign rd_data = empty ? '0 : ram_rd_data;

endmodule
